link_bringup_sequencer: RTL and testbench



---
 rtl/link_bringup_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_link_bringup_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_bringup_sequencer.sv
// Link bring-up sequencer: phased schedule of link_ready, FIFO write enables
// and link reset pulses on write_clk (init wait, rx wait, settle, bursts/gaps,
// optional link reset and re-run). All outputs come straight from flops.
module link_bringup_sequencer #(
    parameter int N_CH       = 1,
    parameter int CNT_W      = 16,
    parameter int INIT_WAIT  = 4000,
    parameter int SETTLE_LEN = 100,
    parameter int BURST_LEN  = 1500,
    parameter int GAP_LEN    = 1,
    parameter int N_BURSTS   = 2,
    parameter int N_PASSES   = 2,
    parameter int RST_LEN    = 3,
    parameter int RX_TIMEOUT = 0,
    parameter int CH_MODE    = 0
) (
    input  logic             write_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             rxinit_done,
    output logic             link_ready,
    output logic [N_CH-1:0]  we,
    output logic             link_reset,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       pass_idx,
    output logic [CNT_W-1:0] burst_idx
);

    localparam longint MAX_LEN = (longint'(1) << CNT_W) - 1;

    // Reject parameter sets the counters cannot represent.
    if (N_CH < 1 || N_CH > 8 || CH_MODE < 0 || CH_MODE > 1 ||
        INIT_WAIT < 1 || SETTLE_LEN < 1 || BURST_LEN < 1 || GAP_LEN < 1 ||
        N_BURSTS < 1 || N_PASSES < 1 || RST_LEN < 1 || RX_TIMEOUT < 0 ||
        INIT_WAIT > MAX_LEN || SETTLE_LEN > MAX_LEN || BURST_LEN > MAX_LEN ||
        GAP_LEN > MAX_LEN || N_BURSTS > MAX_LEN || N_PASSES > MAX_LEN ||
        RST_LEN > MAX_LEN || RX_TIMEOUT > MAX_LEN) begin : g_bad_params
        $error("link_bringup_sequencer: parameter out of range for CNT_W");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT_RX, S_SETTLE, S_BURST, S_GAP, S_LRST, S_DONE, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [2:0]         ch_q, ch_d;

    logic               link_ready_q, link_ready_d;
    logic [N_CH-1:0]    we_q, we_d;
    logic               link_reset_q, link_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2:0]         pass_idx_q, pass_idx_d;
    logic [CNT_W-1:0]   burst_idx_q, burst_idx_d;

    // Next-state, phase counters and the output values for the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        pass_d  = pass_q;
        burst_d = burst_q;
        ch_d    = ch_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_INIT;
                    pass_d  = '0;
                    burst_d = '0;
                    ch_d    = '0;
                end
            end
            S_INIT: begin
                if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
                    state_d = S_WAIT_RX;
                    cnt_d   = '0;
                end
            end
            S_WAIT_RX: begin
                if (rxinit_done) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (RX_TIMEOUT != 0 && cnt_q == CNT_W'(RX_TIMEOUT - 1)) begin
                    state_d = S_ERROR;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LEN - 1)) begin
                    state_d = S_BURST;
                    cnt_d   = '0;
                end
            end
            S_BURST: begin
                if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                    cnt_d = '0;
                    // Round-robin channel pointer keeps running across passes.
                    ch_d  = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;
                    if (burst_q < CNT_W'(N_BURSTS - 1)) begin
                        state_d = S_GAP;
                    end else if (pass_q < CNT_W'(N_PASSES - 1)) begin
                        state_d = S_LRST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
                    state_d = S_BURST;
                    cnt_d   = '0;
                    burst_d = burst_q + 1'b1;
                end
            end
            S_LRST: begin
                if (cnt_q == CNT_W'(RST_LEN - 1)) begin
                    state_d = S_WAIT_RX;
                    cnt_d   = '0;
                    pass_d  = pass_q + 1'b1;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pass_d  = '0;
            burst_d = '0;
            ch_d    = '0;
        end

        link_ready_d = (state_d == S_SETTLE) || (state_d == S_BURST) || (state_d == S_GAP);
        link_reset_d = (state_d == S_LRST);
        busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
        done_d       = (state_d == S_DONE);
        err_d        = (state_d == S_ERROR);
        pass_idx_d   = 3'(pass_d);
        burst_idx_d  = burst_d;
        we_d         = '0;
        if (state_d == S_BURST) begin
            we_d = (CH_MODE == 0) ? {N_CH{1'b1}} : (N_CH'(1) << ch_d);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pass_q       <= '0;
            burst_q      <= '0;
            ch_q         <= '0;
            link_ready_q <= 1'b0;
            we_q         <= '0;
            link_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pass_idx_q   <= '0;
            burst_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            burst_q      <= burst_d;
            ch_q         <= ch_d;
            link_ready_q <= link_ready_d;
            we_q         <= we_d;
            link_reset_q <= link_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            pass_idx_q   <= pass_idx_d;
            burst_idx_q  <= burst_idx_d;
        end
    end

    assign link_ready = link_ready_q;
    assign we         = we_q;
    assign link_reset = link_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pass_idx   = pass_idx_q;
    assign burst_idx  = burst_idx_q;

endmodule

// File: tb/tb_link_bringup_sequencer.sv
// Bench for link_bringup_sequencer: two differently parameterised instances
// share one set of inputs and are compared every cycle against a schedule
// model built from phase names and remaining-cycle countdowns.
module tb_link_bringup_sequencer;

    // Instance 0: round-robin, two passes, timeout. Instance 1: all-channel,
    // single-cycle bursts, one pass, no timeout.
    localparam int P_NCH   [2] = '{4, 2};
    localparam int P_CNTW  [2] = '{8, 6};
    localparam int P_INIT  [2] = '{5, 4};
    localparam int P_SET   [2] = '{3, 2};
    localparam int P_BL    [2] = '{4, 1};
    localparam int P_GAP   [2] = '{2, 1};
    localparam int P_NB    [2] = '{3, 4};
    localparam int P_NP    [2] = '{2, 1};
    localparam int P_RST   [2] = '{3, 1};
    localparam int P_TO    [2] = '{12, 0};
    localparam int P_MODE  [2] = '{1, 0};

    localparam int PH_IDLE = 0, PH_INIT = 1, PH_WAIT = 2, PH_SETTLE = 3, PH_BURST = 4,
                   PH_GAP = 5, PH_LRST = 6, PH_DONE = 7, PH_ERR = 8;

    logic clk = 1'b0;
    logic reset, start, abort, rxinit_done;

    logic                  lr_a, lrst_a, busy_a, done_a, err_a;
    logic [P_NCH[0]-1:0]   we_a;
    logic [2:0]            pass_a;
    logic [P_CNTW[0]-1:0]  burst_a;
    logic                  lr_b, lrst_b, busy_b, done_b, err_b;
    logic [P_NCH[1]-1:0]   we_b;
    logic [2:0]            pass_b;
    logic [P_CNTW[1]-1:0]  burst_b;

    link_bringup_sequencer #(
        .N_CH(P_NCH[0]), .CNT_W(P_CNTW[0]), .INIT_WAIT(P_INIT[0]), .SETTLE_LEN(P_SET[0]),
        .BURST_LEN(P_BL[0]), .GAP_LEN(P_GAP[0]), .N_BURSTS(P_NB[0]), .N_PASSES(P_NP[0]),
        .RST_LEN(P_RST[0]), .RX_TIMEOUT(P_TO[0]), .CH_MODE(P_MODE[0])
    ) dut_a (
        .write_clk(clk), .reset(reset), .start(start), .abort(abort),
        .rxinit_done(rxinit_done), .link_ready(lr_a), .we(we_a), .link_reset(lrst_a),
        .busy(busy_a), .done(done_a), .err(err_a), .pass_idx(pass_a), .burst_idx(burst_a)
    );

    link_bringup_sequencer #(
        .N_CH(P_NCH[1]), .CNT_W(P_CNTW[1]), .INIT_WAIT(P_INIT[1]), .SETTLE_LEN(P_SET[1]),
        .BURST_LEN(P_BL[1]), .GAP_LEN(P_GAP[1]), .N_BURSTS(P_NB[1]), .N_PASSES(P_NP[1]),
        .RST_LEN(P_RST[1]), .RX_TIMEOUT(P_TO[1]), .CH_MODE(P_MODE[1])
    ) dut_b (
        .write_clk(clk), .reset(reset), .start(start), .abort(abort),
        .rxinit_done(rxinit_done), .link_ready(lr_b), .we(we_b), .link_reset(lrst_b),
        .busy(busy_b), .done(done_b), .err(err_b), .pass_idx(pass_b), .burst_idx(burst_b)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: phase, cycles left in it, rx wait count,
    // pass/burst indices and number of bursts completed since start.
    int m_ph [2], m_rem [2], m_wait [2], m_pass [2], m_burst [2], m_nb [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = PH_IDLE; m_rem[i] = 0; m_wait[i] = 0;
            m_pass[i] = 0; m_burst[i] = 0; m_nb[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        if (abort) begin
            m_ph[i] = PH_IDLE; m_pass[i] = 0; m_burst[i] = 0;
            return;
        end
        case (m_ph[i])
            PH_IDLE, PH_DONE, PH_ERR:
                if (start) begin
                    m_ph[i] = PH_INIT; m_rem[i] = P_INIT[i];
                    m_pass[i] = 0; m_burst[i] = 0; m_nb[i] = 0;
                end
            PH_INIT: begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin m_ph[i] = PH_WAIT; m_wait[i] = 0; end
            end
            PH_WAIT:
                if (rxinit_done) begin
                    m_ph[i] = PH_SETTLE; m_rem[i] = P_SET[i];
                end else begin
                    m_wait[i]++;
                    if (P_TO[i] != 0 && m_wait[i] == P_TO[i]) m_ph[i] = PH_ERR;
                end
            PH_SETTLE: begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin m_ph[i] = PH_BURST; m_rem[i] = P_BL[i]; end
            end
            PH_BURST: begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_nb[i]++;
                    if (m_burst[i] < P_NB[i] - 1) begin
                        m_ph[i] = PH_GAP; m_rem[i] = P_GAP[i];
                    end else if (m_pass[i] < P_NP[i] - 1) begin
                        m_ph[i] = PH_LRST; m_rem[i] = P_RST[i];
                    end else begin
                        m_ph[i] = PH_DONE;
                    end
                end
            end
            PH_GAP: begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_burst[i]++; m_ph[i] = PH_BURST; m_rem[i] = P_BL[i];
                end
            end
            PH_LRST: begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_pass[i]++; m_burst[i] = 0; m_ph[i] = PH_WAIT; m_wait[i] = 0;
                end
            end
            default: m_ph[i] = PH_IDLE;
        endcase
    endtask

    // Packed view: {link_ready, we[7:0], link_reset, busy, done, err, pass[2:0], burst[15:0]}
    function automatic logic [31:0] model_out(input int i);
        logic [7:0] w;
        logic       lr, bsy;
        w = 8'd0;
        if (m_ph[i] == PH_BURST)
            w = (P_MODE[i] == 0) ? 8'((1 << P_NCH[i]) - 1) : 8'(1 << (m_nb[i] % P_NCH[i]));
        lr  = (m_ph[i] == PH_SETTLE) || (m_ph[i] == PH_BURST) || (m_ph[i] == PH_GAP);
        bsy = !((m_ph[i] == PH_IDLE) || (m_ph[i] == PH_DONE) || (m_ph[i] == PH_ERR));
        return {lr, w, (m_ph[i] == PH_LRST), bsy, (m_ph[i] == PH_DONE), (m_ph[i] == PH_ERR),
                3'(m_pass[i]), 16'(m_burst[i])};
    endfunction

    function automatic logic [31:0] dut_out(input int i);
        if (i == 0) return {lr_a, 8'(we_a), lrst_a, busy_a, done_a, err_a, pass_a, 16'(burst_a)};
        return {lr_b, 8'(we_b), lrst_b, busy_b, done_b, err_b, pass_b, 16'(burst_b)};
    endfunction

    // One clock: advance the model with the inputs the DUTs sampled, then compare.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else begin model_step(0); model_step(1); end
        #1;
        chk("a_out", dut_out(0), model_out(0));
        chk("b_out", dut_out(1), model_out(1));
        chk("a_we_onehot", 32'($countones(we_a) <= 1), 32'd1);
    endtask

    task automatic wait_phase_a(input string tag, input int ph, input int max_cyc);
        int n;
        n = 0;
        while (m_ph[0] != ph && n < max_cyc) begin cycle(); n++; end
        chk(tag, 32'(m_ph[0] == ph), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rxinit_done = 1'b0;
        model_reset();
        repeat (3) cycle();
        reset = 1'b0;

        // Idle with rx toggling: nothing may happen without start.
        for (int k = 0; k < 8; k++) begin rxinit_done = 1'($urandom_range(0, 1)); cycle(); end

        // Full schedule, rx rising 10 cycles after start.
        rxinit_done = 1'b0; start = 1'b1; cycle(); start = 1'b0;
        for (int k = 0; k < 120; k++) begin
            if (k == 9) rxinit_done = 1'b1;
            cycle();
        end
        chk("a_done_end", {31'd0, done_a}, 32'd1);
        chk("a_lr_end", {31'd0, lr_a}, 32'd0);
        chk("b_done_end", {31'd0, done_b}, 32'd1);

        // rx never arrives: instance 0 times out; instance 1 keeps waiting.
        rxinit_done = 1'b0; start = 1'b1; cycle(); start = 1'b0;
        repeat (30) cycle();
        chk("a_err_timeout", {31'd0, err_a}, 32'd1);
        chk("b_still_busy", {31'd0, busy_b}, 32'd1);
        // Restart: instance 0 reruns, instance 1 ignores start while busy.
        rxinit_done = 1'b1; start = 1'b1; cycle(); start = 1'b0;
        repeat (70) cycle();
        chk("a_done_after_err", {31'd0, done_a}, 32'd1);

        // Random episodes with sporadic start, abort and rx.
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 150; k++) begin
                start       = ($urandom_range(0, 19) == 0);
                abort       = ($urandom_range(0, 59) == 0);
                rxinit_done = ($urandom_range(0, 9) < 7);
                cycle();
            end
        end
        start = 1'b0; abort = 1'b0;

        // abort together with start mid-burst wins; a later start restarts cleanly.
        abort = 1'b1; cycle(); abort = 1'b0;
        rxinit_done = 1'b1; start = 1'b1; cycle(); start = 1'b0;
        wait_phase_a("wait_burst", PH_BURST, 60);
        repeat (2) cycle();
        abort = 1'b1; start = 1'b1; cycle(); abort = 1'b0; start = 1'b0;
        chk("abort_idle", dut_out(0), 32'd0);
        start = 1'b1; cycle(); start = 1'b0;
        chk("restart_pass0", {29'd0, pass_a}, 32'd0);
        chk("restart_busy", {31'd0, busy_a}, 32'd1);

        // Asynchronous reset in the middle of the link reset pulse.
        wait_phase_a("wait_lrst", PH_LRST, 80);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_a", dut_out(0), 32'd0);
        chk("async_rst_b", dut_out(1), 32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin rxinit_done = 1'($urandom_range(0, 1)); cycle(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
